// File: rtl/lite_s2mm_sequencer_pkg.sv
// Shared definitions for the S2MM sequencer: DMA register map, DMASR bit positions,
// FSM state encoding and the err_code values reported to the write-path control.
package lite_s2mm_sequencer_pkg;

   localparam logic [11:0] REG_DMACR  = 12'h030;
   localparam logic [11:0] REG_DMASR  = 12'h034;
   localparam logic [11:0] REG_DA     = 12'h048;
   localparam logic [11:0] REG_LENGTH = 12'h058;

   localparam logic [31:0] DMACR_RS = 32'h0000_0001;

   localparam int SR_IDLE   = 1;
   localparam int SR_INTERR = 4;
   localparam int SR_SLVERR = 5;
   localparam int SR_DECERR = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_CR,
      ST_WR_DA,
      ST_WR_LEN,
      ST_RD_SR,
      ST_GAP,
      ST_DONE,
      ST_ERR
   } state_t;

   typedef enum logic [2:0] {
      EC_NONE     = 3'd0,
      EC_BRESP    = 3'd1,
      EC_RRESP    = 3'd2,
      EC_DMASR    = 3'd3,
      EC_ZERO_LEN = 3'd4,
      EC_TIMEOUT  = 3'd5
   } err_code_t;

endpackage

// File: rtl/lite_wr_channel.sv
// One AXI4-Lite write: aw/w raised the cycle after go, each dropped the cycle after its own ready.
// Backpressure: valids hold until ready; bready stays high until B is taken; go is ignored while active.
module lite_wr_channel #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic              active,
   output logic              done,
   output logic [1:0]        resp
);

   assign bready = active;
   assign done   = active & bvalid;
   assign resp   = bresp;

   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
      end else if (go && !active) begin
         active  <= 1'b1;
         awvalid <= 1'b1;
         wvalid  <= 1'b1;
         awaddr  <= addr;
         wdata   <= data;
      end else begin
         if (awvalid && awready) awvalid <= 1'b0;
         if (wvalid && wready)   wvalid  <= 1'b0;
         // a response closes the transaction outright, even from a slave that answered early
         if (done) begin
            active  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/lite_s2mm_sequencer.sv
// Programs DMACR/DA/LENGTH then polls DMASR every POLL_GAP cycles; done/err pulse one cycle after the deciding read.
// Every channel waits on its ready/valid; LITE_POLL_TIMEOUT_EN bounds polling to POLL_MAX reads.
module lite_s2mm_sequencer
   import lite_s2mm_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int LEN_W    = 26,
   parameter int POLL_GAP = 16,
   parameter int POLL_MAX = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       dest_addr,
   input  logic [LEN_W-1:0]  xfer_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic [ADDR_W-1:0] m_axi_lite_awaddr,
   output logic              m_axi_lite_awvalid,
   input  logic              m_axi_lite_awready,
   output logic [31:0]       m_axi_lite_wdata,
   output logic              m_axi_lite_wvalid,
   input  logic              m_axi_lite_wready,
   input  logic [1:0]        m_axi_lite_bresp,
   input  logic              m_axi_lite_bvalid,
   output logic              m_axi_lite_bready,
   output logic [ADDR_W-1:0] m_axi_lite_araddr,
   output logic              m_axi_lite_arvalid,
   input  logic              m_axi_lite_arready,
   input  logic [31:0]       m_axi_lite_rdata,
   input  logic [1:0]        m_axi_lite_rresp,
   input  logic              m_axi_lite_rvalid,
   output logic              m_axi_lite_rready
);

   localparam int GAP_W = $clog2(POLL_GAP) + 1;

   state_t            state, state_nxt;
   err_code_t         err_code_q, ec_nxt;
   logic [31:0]       dest_q;
   logic [LEN_W-1:0]  len_q;
   logic              accept;
   logic [GAP_W-1:0]  gap_cnt;

   logic              ch_go, ch_active, ch_done;
   logic [1:0]        ch_resp;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   logic              rd_go, rd_active, rd_done;
   logic              sr_err, sr_idle;
   logic              unused_rdata;

`ifdef LITE_POLL_TIMEOUT_EN
   localparam int PC_W = $clog2(POLL_MAX) + 1;
   logic [PC_W-1:0] poll_cnt;
   logic            poll_last;
   assign poll_last = (poll_cnt == PC_W'(POLL_MAX - 1));
`else
   localparam int unused_poll_max = POLL_MAX;
`endif

   assign err_code = err_code_q;
   assign rd_done  = m_axi_lite_rready & m_axi_lite_rvalid;
   assign sr_err   = m_axi_lite_rdata[SR_INTERR] | m_axi_lite_rdata[SR_SLVERR] | m_axi_lite_rdata[SR_DECERR];
   assign sr_idle  = m_axi_lite_rdata[SR_IDLE];
   assign unused_rdata = ^{m_axi_lite_rdata[31:7], m_axi_lite_rdata[3:2], m_axi_lite_rdata[0]};

   lite_wr_channel #(.ADDR_W(ADDR_W)) u_wr (
      .clk     (clk),
      .rst     (rst),
      .go      (ch_go),
      .addr    (wr_addr),
      .data    (wr_data),
      .awaddr  (m_axi_lite_awaddr),
      .awvalid (m_axi_lite_awvalid),
      .awready (m_axi_lite_awready),
      .wdata   (m_axi_lite_wdata),
      .wvalid  (m_axi_lite_wvalid),
      .wready  (m_axi_lite_wready),
      .bresp   (m_axi_lite_bresp),
      .bvalid  (m_axi_lite_bvalid),
      .bready  (m_axi_lite_bready),
      .active  (ch_active),
      .done    (ch_done),
      .resp    (ch_resp)
   );

   always_comb begin
      wr_addr = ADDR_W'(REG_DMACR);
      wr_data = DMACR_RS;
      case (state)
         ST_WR_DA: begin
            wr_addr = ADDR_W'(REG_DA);
            wr_data = dest_q;
         end
         ST_WR_LEN: begin
            wr_addr = ADDR_W'(REG_LENGTH);
            wr_data = 32'(len_q);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ec_nxt    = err_code_q;
      accept    = 1'b0;
      ch_go     = 1'b0;
      rd_go     = 1'b0;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      err       = (state == ST_ERR);
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (xfer_len == '0) begin
                  state_nxt = ST_ERR;
                  ec_nxt    = EC_ZERO_LEN;
               end else begin
                  state_nxt = ST_WR_CR;
                  ec_nxt    = EC_NONE;
               end
            end
         end
         ST_WR_CR, ST_WR_DA, ST_WR_LEN: begin
            ch_go = !ch_active;
            if (ch_done) begin
               if (ch_resp != 2'b00) begin
                  state_nxt = ST_ERR;
                  ec_nxt    = EC_BRESP;
               end else if (state == ST_WR_CR) begin
                  state_nxt = ST_WR_DA;
               end else if (state == ST_WR_DA) begin
                  state_nxt = ST_WR_LEN;
               end else begin
                  // LENGTH is written last because it kicks the engine off
                  state_nxt = ST_RD_SR;
               end
            end
         end
         ST_RD_SR: begin
            rd_go = !rd_active;
            if (rd_done) begin
               if (m_axi_lite_rresp != 2'b00) begin
                  state_nxt = ST_ERR;
                  ec_nxt    = EC_RRESP;
               end else if (sr_err) begin
                  state_nxt = ST_ERR;
                  ec_nxt    = EC_DMASR;
               end else if (sr_idle) begin
                  state_nxt = ST_DONE;
`ifdef LITE_POLL_TIMEOUT_EN
               end else if (poll_last) begin
                  state_nxt = ST_ERR;
                  ec_nxt    = EC_TIMEOUT;
`endif
               end else begin
                  state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nxt = ST_RD_SR;
         end
         ST_DONE, ST_ERR: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         err_code_q <= EC_NONE;
         dest_q     <= '0;
         len_q      <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         err_code_q <= ec_nxt;
         gap_cnt    <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
         if (accept) begin
            dest_q <= dest_addr;
            len_q  <= xfer_len;
         end
      end
   end

   // DMASR read: AR first, then R accepted with rready raised only after the address is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_active          <= 1'b0;
         m_axi_lite_arvalid <= 1'b0;
         m_axi_lite_rready  <= 1'b0;
         m_axi_lite_araddr  <= '0;
      end else if (rd_go) begin
         rd_active          <= 1'b1;
         m_axi_lite_arvalid <= 1'b1;
         m_axi_lite_araddr  <= ADDR_W'(REG_DMASR);
      end else begin
         if (m_axi_lite_arvalid && m_axi_lite_arready) begin
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b1;
         end
         if (rd_done) begin
            m_axi_lite_rready <= 1'b0;
            rd_active         <= 1'b0;
         end
      end
   end

`ifdef LITE_POLL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         poll_cnt <= '0;
      end else if (state == ST_WR_LEN && ch_done) begin
         poll_cnt <= '0;
      end else if (rd_done) begin
         poll_cnt <= poll_cnt + PC_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_lite_s2mm_sequencer.sv
// Bench for lite_s2mm_sequencer: behavioural AXI-Lite slave with per-channel delays,
// expected-write scoreboard, and per-scenario tasks.
module tb_lite_s2mm_sequencer;

   localparam int ADDR_W   = 10;
   localparam int LEN_W    = 26;
   localparam int POLL_GAP = 3;
   localparam int POLL_MAX = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start;
   logic [31:0]       dest_addr;
   logic [LEN_W-1:0]  xfer_len;
   logic              busy, done, err;
   logic [2:0]        err_code;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0]       wdata, rdata;
   logic [1:0]        bresp, rresp;
   logic              arvalid, arready, rvalid, rready;

   lite_s2mm_sequencer #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .xfer_len(xfer_len),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
      .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
      .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
      .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
      .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
      .m_axi_lite_rready(rready)
   );

   int checks = 0;
   int errors = 0;

   int  aw_dly, w_dly, b_dly, r_dly;
   int  aw_wait, w_wait, b_wait, r_wait;
   bit  aw_got, w_got, b_pend, b_fire, ar_got, r_fire, aw_hold, w_hold;
   logic [ADDR_W-1:0] cap_a, hold_a, bad_a;
   logic [31:0]       cap_d, hold_d, sr_default;
   bit  bad_en;
   logic [31:0] sr_q[$];
   wr_t exp_q[$];
   int  wr_cnt, rd_cnt, act_cnt, done_cnt, err_cnt;

   // Slave decisions are made at negedge and take effect on the following posedge.
   task automatic slave_loop();
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0;
            aw_got = 0; w_got = 0; b_pend = 0; b_fire = 0; ar_got = 0; r_fire = 0;
            aw_hold = 0; w_hold = 0; aw_wait = 0; w_wait = 0;
         end else begin
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (awvalid || wvalid || arvalid) act_cnt++;
            if (b_fire) begin bvalid = 0; bresp = 0; b_pend = 0; aw_got = 0; w_got = 0; b_fire = 0; end
            if (r_fire) begin rvalid = 0; ar_got = 0; r_fire = 0; end
            if (aw_hold) begin
               checks++;
               if (awvalid !== 1'b1 || awaddr !== hold_a) begin
                  errors++;
                  $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1 %h", awvalid, awaddr, hold_a);
               end
            end
            if (w_hold) begin
               checks++;
               if (wvalid !== 1'b1 || wdata !== hold_d) begin
                  errors++;
                  $display("FAIL w_stable: wvalid=%b wdata=%h, required 1 %h", wvalid, wdata, hold_d);
               end
            end
            if (aw_got) begin
               checks++;
               if (awvalid !== 1'b0) begin
                  errors++;
                  $display("FAIL early_aw: awvalid=%b with B outstanding, required 0", awvalid);
               end
            end
            if (aw_got && w_got && !b_pend) begin b_pend = 1; b_wait = 0; end
            if (b_pend && !bvalid) begin
               if (b_wait >= b_dly) begin
                  bvalid = 1;
                  bresp  = (bad_en && cap_a == bad_a) ? 2'd2 : 2'd0;
               end else b_wait++;
            end
            if (ar_got && !rvalid) begin
               if (r_wait >= r_dly) begin
                  rvalid = 1;
                  rdata  = (sr_q.size() > 0) ? sr_q.pop_front() : sr_default;
               end else r_wait++;
            end
            awready = 0;
            if (awvalid && !aw_got) begin
               if (aw_wait >= aw_dly) awready = 1; else aw_wait++;
            end
            wready = 0;
            if (wvalid && !w_got) begin
               if (w_wait >= w_dly) wready = 1; else w_wait++;
            end
            arready = !ar_got;
            aw_hold = awvalid && !awready;
            hold_a  = awaddr;
            w_hold  = wvalid && !wready;
            hold_d  = wdata;
            if (awvalid && awready) begin aw_got = 1; cap_a = awaddr; aw_wait = 0; end
            if (wvalid && wready)   begin w_got = 1; cap_d = wdata; w_wait = 0; end
            if (arvalid && arready) begin
               ar_got = 1; r_wait = 0; rd_cnt++;
               checks++;
               if (araddr !== 10'h034) begin
                  errors++;
                  $display("FAIL araddr: got %h, required 034", araddr);
               end
            end
            if (rvalid && rready) r_fire = 1;
            if (bvalid && bready) begin
               b_fire = 1;
               wr_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL write_order: unexpected write %h/%h", cap_a, cap_d);
               end else begin
                  wr_t e;
                  e = exp_q.pop_front();
                  if (cap_a !== e.a || cap_d !== e.d) begin
                     errors++;
                     $display("FAIL write_order: got %h/%h, required %h/%h", cap_a, cap_d, e.a, e.d);
                  end
               end
            end
         end
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic do_start(input logic [31:0] a, input logic [LEN_W-1:0] l);
      @(negedge clk);
      dest_addr = a; xfer_len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_finish(input string name);
      int n = 0;
      while (!(done || err) && n < 3000) begin @(negedge clk); n++; end
      checks++;
      if (!(done || err)) begin
         errors++;
         $display("FAIL %s_end: no done/err after %0d cycles, required a pulse", name, n);
      end else begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: busy/done/err=%b%b%b, required 000", name, busy, done, err);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_result(input string name, input int d0, input int e0, input int w0, input int r0,
                               input int exp_done, input int exp_wr, input int exp_rd, input logic [2:0] exp_code);
      checks++;
      if (done_cnt - d0 != exp_done || err_cnt - e0 != 1 - exp_done) begin
         errors++;
         $display("FAIL %s_pulses: done=%0d err=%0d, required done=%0d err=%0d", name,
                  done_cnt - d0, err_cnt - e0, exp_done, 1 - exp_done);
      end
      checks++;
      if (err_code !== exp_code) begin
         errors++;
         $display("FAIL %s_code: err_code=%0d, required %0d", name, err_code, exp_code);
      end
      checks++;
      if (wr_cnt - w0 != exp_wr || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_writes: %0d writes, %0d left, required %0d and 0", name, wr_cnt - w0, exp_q.size(), exp_wr);
      end
      checks++;
      if (rd_cnt - r0 != exp_rd) begin
         errors++;
         $display("FAIL %s_reads: %0d reads, required %0d", name, rd_cnt - r0, exp_rd);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({busy, done, err, awvalid, wvalid, bready, arvalid, rready} !== 8'h00 || err_code !== 3'd0) begin
         errors++;
         $display("FAIL %s_ctl: busy/done/err/aw/w/b/ar/r=%b code=%0d, required 0", name,
                  {busy, done, err, awvalid, wvalid, bready, arvalid, rready}, err_code);
      end
      checks++;
      if (awaddr !== '0 || wdata !== '0 || araddr !== '0) begin
         errors++;
         $display("FAIL %s_bus: awaddr=%h wdata=%h araddr=%h, required 0", name, awaddr, wdata, araddr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_nominal();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0;
      sr_q = '{32'h0, 32'h0, 32'h2};
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'h1000_0000); push_wr(10'h058, 32'd256);
      do_start(32'h1000_0000, 26'd256);
      wait_finish("nominal");
      check_result("nominal", d0, e0, w0, r0, 1, 3, 3, 3'd0);
   endtask

   task automatic test_backpressure();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      aw_dly = 7; w_dly = 2; b_dly = 7; r_dly = 2;
      sr_q = '{32'h0, 32'h2};
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'h2345_6780); push_wr(10'h058, 32'h0300_0001);
      do_start(32'h2345_6780, 26'h300_0001);
      wait_finish("backpressure");
      check_result("backpressure", d0, e0, w0, r0, 1, 3, 2, 3'd0);
      aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0;
   endtask

   task automatic test_write_error();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      bad_en = 1; bad_a = 10'h048;
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'hABCD_0000);
      do_start(32'hABCD_0000, 26'd64);
      wait_finish("wr_error");
      check_result("wr_error", d0, e0, w0, r0, 0, 2, 0, 3'd1);
      bad_en = 0;
   endtask

   task automatic test_engine_error();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      sr_q = '{32'h22};
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'h0000_4000); push_wr(10'h058, 32'd4);
      do_start(32'h0000_4000, 26'd4);
      wait_finish("engine_error");
      check_result("engine_error", d0, e0, w0, r0, 0, 3, 1, 3'd3);
   endtask

   task automatic test_zero_len();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt, a0 = act_cnt;
      do_start(32'h5555_0000, 26'd0);
      wait_finish("zero_len");
      check_result("zero_len", d0, e0, w0, r0, 0, 0, 0, 3'd4);
      checks++;
      if (act_cnt != a0) begin
         errors++;
         $display("FAIL zero_len_bus: %0d active cycles, required 0", act_cnt - a0);
      end
   endtask

   task automatic test_busy_ignore();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      int n = 0;
      sr_q = '{32'h0, 32'h0, 32'h2};
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'h0BAD_F000); push_wr(10'h058, 32'd128);
      do_start(32'h0BAD_F000, 26'd128);
      while (rready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      @(negedge clk);
      dest_addr = 32'hDEAD_BEEF; xfer_len = 26'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_finish("busy_ignore");
      repeat (10) @(negedge clk);
      check_result("busy_ignore", d0, e0, w0, r0, 1, 3, 3, 3'd0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore_idle: busy=%b after completion, required 0", busy);
      end
   endtask

   task automatic test_timeout();
      int d0 = done_cnt, e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      sr_default = 32'h0;
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'h0000_8000); push_wr(10'h058, 32'd32);
      do_start(32'h0000_8000, 26'd32);
      wait_finish("timeout");
      check_result("timeout", d0, e0, w0, r0, 0, 3, POLL_MAX, 3'd5);
      sr_default = 32'h2;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      sr_default = 32'h0;
      push_wr(10'h030, 32'h1); push_wr(10'h048, 32'h0000_C000); push_wr(10'h058, 32'd16);
      do_start(32'h0000_C000, 26'd16);
      while (arvalid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (arvalid !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_reach: arvalid=%b, required 1", arvalid);
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_mid");
      @(negedge clk);
      rst = 1'b0;
      sr_default = 32'h2;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      start = 0; dest_addr = '0; xfer_len = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = '0;
      aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0; bad_en = 0; bad_a = '0; sr_default = 32'h2;
      wr_cnt = 0; rd_cnt = 0; act_cnt = 0; done_cnt = 0; err_cnt = 0;
      fork
         slave_loop();
      join_none
      test_reset();
      test_nominal();
      test_backpressure();
      test_write_error();
      test_engine_error();
      test_zero_len();
      test_busy_ignore();
`ifdef LITE_POLL_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
